// File: rtl/sample_unpacker.sv
// sample_unpacker: turns one wide capture word into a serial stream of
// rescaled samples, slice 0 (word LSBs) first. A new word can be loaded on the
// same edge that hands off the last slice, so the stream has no bubbles.
module sample_unpacker #(
  parameter int SAMPLE_WIDTH     = 12,
  parameter int SAMPLES_PER_WORD = 4,
  parameter int OUTPUT_WIDTH     = 12
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clear,
  input  logic [SAMPLE_WIDTH*SAMPLES_PER_WORD-1:0] word_in,
  input  logic                                     word_valid,
  output logic                                     word_ready,
  output logic [OUTPUT_WIDTH-1:0]                  sample_out,
  output logic                                     sample_valid,
  input  logic                                     sample_ready,
  output logic                                     sample_last
);

  localparam int WORD_W = SAMPLE_WIDTH * SAMPLES_PER_WORD;
  localparam int IDX_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [SAMPLE_WIDTH-1:0] slice;
  logic [OUTPUT_WIDTH-1:0] scaled;

  assign slice = word_q[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH];

  // Rescale by bit alignment only: widen with zero LSBs, narrow by keeping MSBs.
  if (OUTPUT_WIDTH > SAMPLE_WIDTH) begin : g_widen
    assign scaled = {slice, {(OUTPUT_WIDTH-SAMPLE_WIDTH){1'b0}}};
  end else if (OUTPUT_WIDTH < SAMPLE_WIDTH) begin : g_narrow
    assign scaled = slice[SAMPLE_WIDTH-1 -: OUTPUT_WIDTH];
  end else begin : g_pass
    assign scaled = slice;
  end

  // Output decode straight from state and index; word_ready never looks at word_valid.
  always_comb begin
    sample_valid = (state_q == EMIT);
    sample_last  = sample_valid && (idx_q == LAST_IDX);
    sample_out   = sample_valid ? scaled : '0;
    word_ready   = !clear && ((state_q == IDLE) || (sample_last && sample_ready));
  end

  // Next-state logic: clear wins, otherwise load / advance / drain.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
      word_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (word_valid) begin
            state_d = EMIT;
            idx_d   = '0;
            word_d  = word_in;
          end
        end
        EMIT: begin
          if (sample_ready) begin
            if (!sample_last) begin
              idx_d = idx_q + IDX_W'(1);
            end else if (word_valid) begin
              idx_d  = '0;
              word_d = word_in;
            end else begin
              state_d = IDLE;
              idx_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, index and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      // NOTE: the holding register is reset on purpose so sample_out and the slice mux start from a known zero.
      word_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_sample_unpacker.sv
// Bench for sample_unpacker: two instances (narrowing to 8 bits, widening to
// 16 bits) share stimulus and are compared every cycle against a queue model
// that holds the slices still owed for the current word.
module tb_sample_unpacker;

  localparam int SW  = 12;
  localparam int SPW = 4;

  logic        clk = 1'b0;
  logic        rst_n, clear, word_valid, sample_ready;
  logic [47:0] word_in;

  logic [7:0]  so8;
  logic [15:0] so16;
  logic        sv8, sv16, sl8, sl16, wr8, wr16;

  always #5 clk = ~clk;

  sample_unpacker #(.SAMPLE_WIDTH(SW), .SAMPLES_PER_WORD(SPW), .OUTPUT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr8), .sample_out(so8), .sample_valid(sv8), .sample_ready(sample_ready),
    .sample_last(sl8)
  );

  sample_unpacker #(.SAMPLE_WIDTH(SW), .SAMPLES_PER_WORD(SPW), .OUTPUT_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr16), .sample_out(so16), .sample_valid(sv16), .sample_ready(sample_ready),
    .sample_last(sl16)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model: slices of the current word not yet handed off.
  logic [11:0] pend[$];
  int          words_acc = 0;

  // Bookkeeping for throughput / sequence checks.
  int          cyc = 0, vcount = 0, first_v = 0, last_v = 0;
  logic [15:0] got[$];
  logic [15:0] ref_seq[$];
  logic [47:0] w3[3];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_out = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rescale(input logic [11:0] s, input int ow);
    if (ow >= SW) return 64'(s) << (ow - SW);
    else          return 64'(s) >> (SW - ow);
  endfunction

  function automatic bit m_ready();
    return !clear && (pend.size() == 0 || (pend.size() == 1 && sample_ready));
  endfunction

  // Model update on each edge from the pre-edge inputs.
  always @(posedge clk) begin
    bit take_w, take_s;
    if (rst_n) begin
      take_w = word_valid && m_ready();
      take_s = (pend.size() > 0) && sample_ready;
      if (clear) begin
        pend.delete();
      end else begin
        if (take_s) void'(pend.pop_front());
        if (take_w) begin
          for (int i = 0; i < SPW; i++) pend.push_back(word_in[i*SW +: SW]);
          words_acc++;
        end
      end
    end
  end

  always @(negedge rst_n) pend.delete();

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      cyc++;
      check("valid8",  sv8,  pend.size() > 0);
      check("valid16", sv16, pend.size() > 0);
      check("last8",   sl8,  pend.size() == 1);
      check("last16",  sl16, pend.size() == 1);
      check("ready8",  wr8,  m_ready());
      check("ready16", wr16, m_ready());
      if (pend.size() > 0) begin
        check("out8",  so8,  rescale(pend[0], 8));
        check("out16", so16, rescale(pend[0], 16));
      end
      if (prev_stall && sv8) check("stall_hold", so8, prev_out);
      prev_stall = sv8 && !sample_ready;
      prev_out   = so8;
      if (sv8) begin
        if (vcount == 0) first_v = cyc;
        last_v = cyc;
        vcount++;
        if (sample_ready && !clear) got.push_back(so16);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed the three fixed words in order; sample_ready asserted with sr_pct %.
  task automatic run_three(input int max_cycles, input int sr_pct);
    for (int c = 0; c < max_cycles; c++) begin
      if (words_acc < 3) begin
        word_valid = 1'b1;
        word_in    = w3[words_acc];
      end else begin
        word_valid = 1'b0;
      end
      sample_ready = ($urandom_range(99) < sr_pct);
      step();
      if (words_acc >= 3 && pend.size() == 0) break;
    end
    word_valid   = 1'b0;
    sample_ready = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0]  exp8[4];
    logic [15:0] exp16[4];
    logic [63:0] r;

    rst_n = 1'b0; clear = 1'b0; word_valid = 1'b0; sample_ready = 1'b0; word_in = '0;
    #3;
    check("rst_ready",  wr8,  1'b1);
    check("rst_valid",  sv8,  1'b0);
    check("rst_last",   sl8,  1'b0);
    check("rst_out8",   so8,  8'h00);
    check("rst_out16",  so16, 16'h0000);
    step(); step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Directed unpack of a known word, literal expectations.
    exp8  = '{8'h12, 8'h45, 8'h78, 8'hAB};
    exp16 = '{16'h1230, 16'h4560, 16'h7890, 16'hABC0};
    word_in = 48'hABC7_8945_6123; word_valid = 1'b1; sample_ready = 1'b1;
    step();
    word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_out8",  so8,  exp8[i]);
      check("lit_out16", so16, exp16[i]);
      check("lit_last",  sl8,  i == 3);
      check("lit_wready", wr8, i == 3);
      step();
    end

    // Back-to-back: three words with no gaps.
    for (int i = 0; i < 3; i++) begin
      r = {$urandom(), $urandom()};
      w3[i] = r[47:0];
    end
    words_acc = 0; vcount = 0; got.delete();
    run_three(40, 100);
    check("b2b_words", words_acc, 3);
    check("b2b_count", vcount, 12);
    check("b2b_span",  last_v - first_v, 11);
    ref_seq = got;

    // Same words under random backpressure: sequence must match.
    words_acc = 0; got.delete();
    run_three(400, 50);
    check("bp_len", got.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < got.size()) check("bp_seq", got[i], ref_seq[i]);
      check("bp_expect", ref_seq[i], rescale(w3[i/4][(i%4)*SW +: SW], 16));
    end

    // clear after the second sample, with a word offered in the same cycle.
    step();
    word_in = 48'h1111_2222_3333; word_valid = 1'b1; sample_ready = 1'b1;
    step();
    word_valid = 1'b0;
    step();
    step();
    clear = 1'b1; word_valid = 1'b1; word_in = 48'h5555_6666_7777;
    step();
    clear = 1'b0; word_valid = 1'b0;
    @(negedge clk);
    check("clr_valid", sv8, 1'b0);
    check("clr_ready", wr8, 1'b1);
    step();
    word_in = 48'h0000_0000_0FED; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    @(negedge clk);
    check("clr_restart8",  so8,  8'hFE);
    check("clr_restart16", so16, 16'hFED0);
    repeat (5) step();

    // Asynchronous reset mid-word.
    word_in = 48'h1234_5678_9ABC; word_valid = 1'b1; sample_ready = 1'b1;
    step();
    word_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    check("arst_valid", sv8, 1'b0);
    check("arst_ready", wr8, 1'b1);
    check("arst_out",   so8, 8'h00);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_post_valid", sv8, 1'b0);
    check("arst_post_ready", wr8, 1'b1);
    step();
    word_in = 48'h0000_0000_0FED; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    @(negedge clk);
    check("arst_restart8", so8, 8'hFE);
    repeat (5) step();

    // Random traffic with occasional clear.
    for (int c = 0; c < 3000; c++) begin
      r = {$urandom(), $urandom()};
      word_in      = r[47:0];
      word_valid   = ($urandom_range(99) < 60);
      sample_ready = ($urandom_range(99) < 60);
      clear        = ($urandom_range(99) < 4);
      step();
    end
    clear = 1'b0; word_valid = 1'b0; sample_ready = 1'b1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
